// File: rtl/pt_tx_scheduler.sv
// Payload FIFO plus frame sequencer for the PT2262 encoder (pt_enc).
// Each queued 24-bit word is sent for REPEATS frames, with a reset guard gap between words.
module pt_tx_scheduler #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned REPEATS    = 4,
    parameter int unsigned GAP_CYCLES = 32,
    parameter int unsigned TIMEOUT    = 1024,
    localparam int unsigned PAYLOAD_W = 24,
    localparam int unsigned LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic [PAYLOAD_W-1:0] s_payload,
    output logic                 s_ready,
    input  logic                 flush,
    input  logic                 enc_done,
    output logic                 enc_rst,
    output logic [PAYLOAD_W-1:0] enc_ad,
    output logic                 busy,
    output logic                 sent_pulse,
    output logic                 timeout_err,
    output logic [LVL_W-1:0]     fifo_level
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned FRAME_W = 8;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    logic [PAYLOAD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LVL_W-1:0]     r_level;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [FRAME_W-1:0]   r_frame_cnt;
    logic [FRAME_W-1:0]   w_frame_nxt;
    logic [FRAME_W-1:0]   w_frame_inc;
    logic [CNT_W-1:0]     r_to_cnt;
    logic [CNT_W-1:0]     w_to_nxt;
    logic [CNT_W-1:0]     r_gap_cnt;
    logic [CNT_W-1:0]     w_gap_nxt;

    logic                 r_enc_rst;
    logic                 w_enc_rst_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_sent;
    logic                 w_sent_nxt;
    logic                 r_terr;
    logic                 w_terr_nxt;
    logic [PAYLOAD_W-1:0] r_enc_ad;

    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;

    // FIFO handshake; flush wins over a concurrent push
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign s_ready = ~w_full;
    assign w_push  = s_valid & ~w_full & ~flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_payload;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_frame_inc = r_frame_cnt + FRAME_W'(1);

    // Next-state and next-output logic; outputs are registered from these values
    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame_cnt;
        w_to_nxt    = r_to_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_sent_nxt  = 1'b0;
        w_terr_nxt  = r_terr;
        w_pop       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!flush && (r_level != '0)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (flush) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_frame_nxt = '0;
                    w_to_nxt    = '0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (flush) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else if (enc_done) begin
                    w_frame_nxt = w_frame_inc;
                    w_to_nxt    = '0;
                    if (w_frame_inc == FRAME_W'(REPEATS)) begin
                        w_sent_nxt  = 1'b1;
                        w_gap_nxt   = '0;
                        w_state_nxt = ST_GAP;
                    end
                end else if (r_to_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_terr_nxt  = 1'b1;
                    w_gap_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_to_nxt = r_to_cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_enc_rst_nxt = (w_state_nxt != ST_SEND);
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_enc_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_sent      <= 1'b0;
            r_terr      <= 1'b0;
            r_enc_ad    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_to_cnt    <= w_to_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_enc_rst   <= w_enc_rst_nxt;
            r_busy      <= w_busy_nxt;
            r_sent      <= w_sent_nxt;
            r_terr      <= w_terr_nxt;
            if (w_pop) begin
                r_enc_ad <= r_mem[r_rd_ptr];
            end
        end
    end

    assign enc_rst     = r_enc_rst;
    assign enc_ad      = r_enc_ad;
    assign busy        = r_busy;
    assign sent_pulse  = r_sent;
    assign timeout_err = r_terr;
    assign fifo_level  = r_level;

endmodule

// File: tb/tb_pt_tx_scheduler.sv
// Bench for pt_tx_scheduler: a free-running pt_enc model plus per-scenario tasks.
// Expected timings follow from frame period, REPEATS, GAP_CYCLES and TIMEOUT arithmetic.
module tb_pt_tx_scheduler;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned REPEATS    = 4;
    localparam int unsigned GAP_CYCLES = 32;
    localparam int unsigned TIMEOUT    = 1024;
    localparam int unsigned LVL_W      = $clog2(DEPTH) + 1;
    localparam int          LIMIT      = 6000;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid;
    logic [23:0]      s_payload;
    logic             s_ready;
    logic             flush;
    logic             enc_done;
    logic             enc_rst;
    logic [23:0]      enc_ad;
    logic             busy;
    logic             sent_pulse;
    logic             timeout_err;
    logic [LVL_W-1:0] fifo_level;

    int          total = 0;
    int          bad = 0;
    int          n_sent = 0;
    int          n_done = 0;
    int          period = 100;
    int          ctr = 0;
    bit          done_en = 1'b1;
    bit          done_force = 1'b0;
    bit          last_acc = 1'b0;
    logic [23:0] got_q [$];

    always #5 clk = ~clk;

    pt_tx_scheduler #(
        .DEPTH      (DEPTH),
        .REPEATS    (REPEATS),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_payload   (s_payload),
        .s_ready     (s_ready),
        .flush       (flush),
        .enc_done    (enc_done),
        .enc_rst     (enc_rst),
        .enc_ad      (enc_ad),
        .busy        (busy),
        .sent_pulse  (sent_pulse),
        .timeout_err (timeout_err),
        .fifo_level  (fifo_level)
    );

    // One clock: note handshake, advance, record completions, run the encoder model
    task automatic step();
        last_acc = (s_valid === 1'b1) && (s_ready === 1'b1) && !flush && !rst;
        @(posedge clk);
        #1;
        if (sent_pulse === 1'b1) begin
            n_sent++;
            got_q.push_back(enc_ad);
        end
        if (done_force) begin
            enc_done = 1'b1;
        end else if (enc_rst === 1'b0 && done_en) begin
            ctr++;
            if (ctr >= period) begin
                enc_done = 1'b1;
                ctr = 0;
                n_done++;
            end else begin
                enc_done = 1'b0;
            end
        end else begin
            ctr = 0;
            enc_done = 1'b0;
        end
    endtask

    task automatic idle_steps(input int k);
        repeat (k) step();
    endtask

    task automatic push_one(input logic [23:0] p, output int waited);
        s_valid = 1'b1;
        s_payload = p;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!last_acc && waited < LIMIT);
        s_valid = 1'b0;
    endtask

    task automatic wait_rst_low(output int n);
        n = 0;
        while (enc_rst !== 1'b0 && n < LIMIT) begin
            step();
            n++;
        end
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (enc_rst === 1'b0 && n < LIMIT) begin
            n++;
            step();
        end
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < LIMIT) begin
            n++;
            step();
        end
    endtask

    task automatic wait_sent(input int target);
        int n;
        n = 0;
        while (n_sent < target && n < 4 * LIMIT) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_payload = '0;
        flush = 1'b0;
        enc_done = 1'b0;
        idle_steps(3);
        total++; if (enc_rst !== 1'b1) begin bad++; $display("FAIL reset_enc_rst: got %0b want 1", enc_rst); end
        total++; if (enc_ad !== 24'h0) begin bad++; $display("FAIL reset_enc_ad: got %h want 000000", enc_ad); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (sent_pulse !== 1'b0) begin bad++; $display("FAIL reset_sent: got %0b want 0", sent_pulse); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_terr: got %0b want 0", timeout_err); end
        total++; if (fifo_level !== LVL_W'(0)) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", s_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int n, lo, hi, base;
        logic [23:0] g;
        period = 100;
        done_en = 1'b1;
        got_q.delete();
        base = n_sent;
        push_one(24'hA5A5A5, n);
        total++; if (n != 1) begin bad++; $display("FAIL single_accept: got wait %0d want 1", n); end
        total++; if (fifo_level !== LVL_W'(1)) begin bad++; $display("FAIL single_level: got %0d want 1", fifo_level); end
        step();
        total++; if (fifo_level !== LVL_W'(0)) begin bad++; $display("FAIL single_pop_level: got %0d want 0", fifo_level); end
        total++; if (enc_ad !== 24'hA5A5A5) begin bad++; $display("FAIL single_load_ad: got %h want a5a5a5", enc_ad); end
        total++; if (busy !== 1'b1 || enc_rst !== 1'b1) begin bad++; $display("FAIL single_load: got busy=%0b enc_rst=%0b want 1 1", busy, enc_rst); end
        wait_rst_low(n);
        total++; if (n != 1) begin bad++; $display("FAIL single_send_latency: got %0d want 1", n); end
        measure_low(lo);
        total++; if (lo != int'(REPEATS) * period) begin bad++; $display("FAIL single_send_len: got %0d want %0d", lo, int'(REPEATS) * period); end
        total++; if (sent_pulse !== 1'b1) begin bad++; $display("FAIL single_sent_pulse: got %0b want 1", sent_pulse); end
        g = (got_q.size() > 0) ? got_q[0] : 24'hx;
        total++; if (n_sent != base + 1 || g !== 24'hA5A5A5) begin bad++; $display("FAIL single_sent: got n=%0d ad=%h want n=%0d ad=a5a5a5", n_sent - base, g, 1); end
        measure_busy(hi);
        total++; if (hi != int'(GAP_CYCLES)) begin bad++; $display("FAIL single_gap: got %0d want %0d", hi, GAP_CYCLES); end
        total++; if (enc_ad !== 24'hA5A5A5 || timeout_err !== 1'b0) begin bad++; $display("FAIL single_after: got ad=%h terr=%0b want a5a5a5 0", enc_ad, timeout_err); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] p [6];
        int w, wsum, base, hi;
        logic [23:0] g;
        period = int'($urandom_range(20, 60));
        got_q.delete();
        base = n_sent;
        wsum = 0;
        for (int i = 0; i < 6; i++) p[i] = 24'($urandom());
        for (int i = 0; i < 6; i++) begin
            push_one(p[i], w);
            if (i < 5) wsum += w;
            if (i == 4) begin
                total++; if (fifo_level !== LVL_W'(DEPTH) || s_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: got level=%0d ready=%0b want %0d 0", fifo_level, s_ready, DEPTH); end
                total++; if (wsum != 5) begin bad++; $display("FAIL b2b_first5: got %0d cycles want 5", wsum); end
            end
        end
        total++; if (w != int'(REPEATS) * period + int'(GAP_CYCLES)) begin bad++; $display("FAIL b2b_stall: got %0d want %0d", w, int'(REPEATS) * period + int'(GAP_CYCLES)); end
        wait_sent(base + 6);
        total++; if (n_sent != base + 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", n_sent - base); end
        for (int i = 0; i < 6; i++) begin
            g = (got_q.size() > i) ? got_q[i] : 24'hx;
            total++; if (g !== p[i]) begin bad++; $display("FAIL b2b_order[%0d]: got %h want %h", i, g, p[i]); end
        end
        measure_busy(hi);
        idle_steps(10);
        total++; if (n_sent != base + 6 || busy !== 1'b0) begin bad++; $display("FAIL b2b_end: got n=%0d busy=%0b want 6 0", n_sent - base, busy); end
    endtask

    task automatic test_timeout();
        logic [23:0] a, b, g;
        int n, lo, base;
        a = 24'($urandom());
        b = 24'($urandom());
        done_en = 1'b0;
        got_q.delete();
        base = n_sent;
        push_one(a, n);
        push_one(b, n);
        wait_rst_low(n);
        measure_low(lo);
        total++; if (lo != int'(TIMEOUT)) begin bad++; $display("FAIL to_len: got %0d want %0d", lo, TIMEOUT); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err: got %0b want 1", timeout_err); end
        total++; if (sent_pulse !== 1'b0 || n_sent != base) begin bad++; $display("FAIL to_nosent: got pulse=%0b n=%0d want 0 0", sent_pulse, n_sent - base); end
        done_en = 1'b1;
        period = int'($urandom_range(20, 60));
        wait_sent(base + 1);
        g = (got_q.size() > 0) ? got_q[0] : 24'hx;
        total++; if (g !== b) begin bad++; $display("FAIL to_next: got %h want %h", g, b); end
        measure_busy(n);
        total++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL to_sticky: got terr=%0b busy=%0b want 1 0", timeout_err, busy); end
    endtask

    task automatic test_flush();
        int n, hi, base, d0, r;
        period = int'($urandom_range(20, 60));
        done_en = 1'b1;
        got_q.delete();
        base = n_sent;
        for (int i = 0; i < 3; i++) push_one(24'($urandom()), n);
        total++; if (fifo_level !== LVL_W'(2)) begin bad++; $display("FAIL flush_queued: got %0d want 2", fifo_level); end
        d0 = n_done;
        n = 0;
        while (n_done < d0 + 2 && n < LIMIT) begin
            step();
            n++;
        end
        step();
        r = int'($urandom_range(1, 32'(period - 4)));
        idle_steps(r);
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (enc_rst !== 1'b1) begin bad++; $display("FAIL flush_enc_rst: got %0b want 1", enc_rst); end
        total++; if (fifo_level !== LVL_W'(0) || s_ready !== 1'b1) begin bad++; $display("FAIL flush_level: got %0d ready=%0b want 0 1", fifo_level, s_ready); end
        total++; if (sent_pulse !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL flush_state: got pulse=%0b busy=%0b want 0 1", sent_pulse, busy); end
        measure_busy(hi);
        total++; if (hi != int'(GAP_CYCLES)) begin bad++; $display("FAIL flush_gap: got %0d want %0d", hi, GAP_CYCLES); end
        idle_steps(int'(REPEATS) * period + int'(GAP_CYCLES) + 10);
        total++; if (n_sent != base || busy !== 1'b0) begin bad++; $display("FAIL flush_dropped: got n=%0d busy=%0b want 0 0", n_sent - base, busy); end
    endtask

    task automatic test_async_reset();
        logic [23:0] c, g;
        int n, lo, base;
        period = int'($urandom_range(20, 60));
        got_q.delete();
        base = n_sent;
        push_one(24'($urandom()), n);
        push_one(24'($urandom()), n);
        wait_rst_low(n);
        idle_steps(int'($urandom_range(3, 10)));
        #2;
        rst = 1'b1;
        #1;
        total++; if (enc_rst !== 1'b1 || fifo_level !== LVL_W'(0)) begin bad++; $display("FAIL arst_immediate: got enc_rst=%0b level=%0d want 1 0", enc_rst, fifo_level); end
        total++; if (busy !== 1'b0 || s_ready !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL arst_outputs: got busy=%0b ready=%0b terr=%0b want 0 1 0", busy, s_ready, timeout_err); end
        step();
        #2;
        rst = 1'b0;
        c = 24'($urandom());
        push_one(c, n);
        wait_rst_low(n);
        measure_low(lo);
        total++; if (lo != int'(REPEATS) * period) begin bad++; $display("FAIL arst_full_repeats: got %0d want %0d", lo, int'(REPEATS) * period); end
        g = (got_q.size() > 0) ? got_q[0] : 24'hx;
        total++; if (g !== c) begin bad++; $display("FAIL arst_payload: got %h want %h", g, c); end
        measure_busy(n);
        idle_steps(20);
        total++; if (n_sent != base + 1) begin bad++; $display("FAIL arst_count: got %0d want 1", n_sent - base); end
    endtask

    task automatic test_push_flush();
        logic [23:0] y, g;
        int n, lo, hi, base;
        period = int'($urandom_range(20, 60));
        got_q.delete();
        base = n_sent;
        s_valid = 1'b1;
        s_payload = 24'($urandom());
        flush = 1'b1;
        step();
        s_valid = 1'b0;
        flush = 1'b0;
        total++; if (fifo_level !== LVL_W'(0)) begin bad++; $display("FAIL pf_dropped: got level %0d want 0", fifo_level); end
        idle_steps(3);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pf_idle: got busy %0b want 0", busy); end
        done_force = 1'b1;
        idle_steps(4);
        done_force = 1'b0;
        step();
        total++; if (busy !== 1'b0 || n_sent != base) begin bad++; $display("FAIL pf_idle_done: got busy=%0b n=%0d want 0 0", busy, n_sent - base); end
        y = 24'($urandom());
        push_one(y, n);
        wait_rst_low(n);
        measure_low(lo);
        total++; if (lo != int'(REPEATS) * period) begin bad++; $display("FAIL pf_repeats: got %0d want %0d", lo, int'(REPEATS) * period); end
        g = (got_q.size() > 0) ? got_q[0] : 24'hx;
        total++; if (g !== y) begin bad++; $display("FAIL pf_payload: got %h want %h", g, y); end
        hi = 0;
        while (busy === 1'b1 && hi < LIMIT) begin
            hi++;
            done_force = bit'($urandom_range(0, 1));
            step();
        end
        done_force = 1'b0;
        total++; if (hi != int'(GAP_CYCLES)) begin bad++; $display("FAIL pf_gap_done: got %0d want %0d", hi, GAP_CYCLES); end
        idle_steps(6);
        total++; if (n_sent != base + 1 || busy !== 1'b0) begin bad++; $display("FAIL pf_end: got n=%0d busy=%0b want 1 0", n_sent - base, busy); end
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        s_payload = '0;
        flush = 1'b0;
        enc_done = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_flush();
        test_async_reset();
        test_push_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
